i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
//  I2C target (slave) responder: the far end of the bus driven by our i2c_init master.
//  Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
//  ACKs its own 7-bit address and streams written bytes out on a valid strobe.
//  Serves read bytes from a request/data interface. Used in loopback benches and as an
//  on-chip model of the IR camera.
// PARAMETERS
//  ADDR  7'h58  7-bit target address; the block ACKs only this address.
// PORTS
//  clk       in   1  system clock, >= 8x SCL rate
//  reset     in   1  synchronous, active-high
//  scl       in   1  raw bus SCL (asynchronous to clk)
//  sda_in    in   1  raw bus SDA (asynchronous to clk)
//  sda_oe    out  1  1 = pull SDA low, 0 = release (open-drain)
//  rx_data   out  8  last written byte, MSB first on the wire
//  rx_valid  out  1  1-cycle strobe: rx_data is new
//  rx_first  out  1  high with rx_valid on the first data byte after the address
//  tx_req    out  1  1-cycle strobe: next read byte is needed
//  tx_data   in   8  read byte; latched on the cycle after tx_req
//  busy      out  1  high from address match until STOP, NACK or non-matching address
//  stop_det  out  1  1-cycle strobe on every STOP seen on the bus
// BEHAVIOUR
//  - Reset values: sda_oe=0, rx_data=0, rx_valid=0, rx_first=0, tx_req=0, busy=0,
//    stop_det=0, state=IDLE.
//  - Input sync: scl and sda_in each pass through 2 FFs, then 1 history FF for edge detect.
//  - Bus events:
//    - scl_rise / scl_fall: synced SCL edges.
//    - START: synced SDA falls while synced SCL is high.
//    - STOP: synced SDA rises while synced SCL is high.
//  - Bit timing: SDA is sampled on scl_rise. sda_oe changes only on scl_fall, except
//    START/STOP, which force sda_oe=0 in the same cycle.
//  - bitcnt: 3 bits, cleared on START and on entry to each byte.
//  - Shift register: 8 bits, MSB first.
//  - FSM states: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK.
//    - START from any state -> ADDR, bitcnt=0. This covers repeated START.
//    - STOP from any state -> IDLE; busy=0; stop_det pulses.
//    - ADDR, 8th scl_rise:
//      - sr[7:1]==ADDR -> ADDR_ACK; busy=1. If R/W=1, tx_req pulses on this cycle.
//      - Mismatch -> IDLE. Bus ignored until the next START; sda_oe stays 0.
//    - ADDR_ACK: next scl_fall sets sda_oe=1. The following scl_fall:
//      - W: sda_oe=0 -> WR.
//      - R: sda_oe=~tx_latched[7] -> RD.
//    - WR, 8th scl_rise: rx_data=sr, rx_valid pulses, rx_first=1 for the first byte only
//      -> WR_ACK (ACK on the next scl_fall, release on the one after) -> WR.
//    - RD: on each scl_fall drive the next bit (sda_oe=~bit). The 8th bit's following
//      scl_fall releases SDA -> RD_ACK.
//    - RD_ACK, scl_rise samples the master's ACK bit:
//      - SDA=0 (ACK): tx_req pulses; the next scl_fall drives the next byte's MSB -> RD.
//      - SDA=1 (NACK): busy=0 -> IDLE with SDA released; waits for STOP/START.
//  - The target never stretches SCL; tx_data must be valid on the cycle after tx_req.
//  - START or STOP mid-byte aborts the byte: no rx_valid, partial bits discarded.
//  - START and scl edge in the same cycle: START wins.
//  - reset mid-transfer: immediate return to IDLE, SDA released within that cycle.
// STRUCTURE
//  - Shared package/header i2c_defs.vh: FSM state localparams (3-bit) and I2C_RW_READ=1'b1.
//    The i2c_init master reuses the same file.
//  - One sub-module: i2c_bus_sync (2-FF sync + edge history; outputs scl_rise, scl_fall,
//    start_det, stop_det, sda_s). The FSM and datapath stay in i2c_target.
// TESTING (bench: i2c_target_tb, BFM master, SCL = clk/16, 10k pull-up model)
//  1. START, 0xB0 (0x58,W), 0xAB, 0xCD, 0xEF, STOP:
//     - ACK on all 4 bytes.
//     - rx_valid x3 with rx_data AB/CD/EF; rx_first only on AB.
//     - stop_det x1; busy low after STOP.
//  2. START, 0x42 (0x21,W), 0x55:
//     - SDA never pulled low (NACK); no rx_valid; busy stays 0.
//  3. START, 0xB1 (0x58,R), tx_data=0x3C then 0xA5, master ACKs byte 1 and NACKs byte 2:
//     - master reads 0x3C, 0xA5; tx_req x2; SDA released after the NACK.
//  4. Write 0x10, then repeated START to 0xB1 with tx_data=0x99:
//     - rx_data=0x10 with rx_first; then read returns 0x99; no stop_det between.
//  5. STOP after 4 bits of a data byte:
//     - no rx_valid; state IDLE.
//     - Next full write 0xB0, 0x77 is received correctly with rx_first.
//  6. reset asserted during the ACK slot:
//     - sda_oe=0 the next cycle; all outputs at reset values; next transaction is clean.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared I2C target definitions: FSM state encoding and bus constants.
// No ports; imported by i2c_target and i2c_target_bus_sync.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR       = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD       = 3'd5,
    ST_RD_ACK   = 3'd6
  } state_e;

  localparam logic       I2C_RW_READ = 1'b1;
  localparam logic [2:0] BIT_LAST    = 3'd7;

endpackage

// File: rtl/i2c_target_bus_sync.sv
// I2C bus front end: 2-FF synchronizers plus one history FF per line.
// Ports: clk, reset, scl_i, sda_i -> scl_rise_o, scl_fall_o,
//        start_det_o, stop_det_o, sda_s_o (synced SDA).
module i2c_target_bus_sync
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);

  // [0],[1] = synchronizer, [2] = history for edge detection
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic [2:0] scl_d;
  logic [2:0] sda_d;

  assign scl_d = {scl_q[1:0], scl_i};
  assign sda_d = {sda_q[1:0], sda_i};

  // Reset to the idle-bus level so release of reset
  // never looks like an edge on a quiet bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign scl_rise_o  =  scl_q[1] & ~scl_q[2];
  assign scl_fall_o  = ~scl_q[1] &  scl_q[2];
  assign start_det_o =  scl_q[1] &  sda_q[2] & ~sda_q[1];
  assign stop_det_o  =  scl_q[1] & ~sda_q[2] &  sda_q[1];
  assign sda_s_o     =  sda_q[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target responder: ACKs address ADDR, streams written bytes out,
// serves read bytes via tx_req/tx_data. Never stretches SCL.
// Ports: clk, reset (sync, active-high), scl, sda_in, sda_oe,
//        rx_data/rx_valid/rx_first, tx_req/tx_data, busy, stop_det.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h58
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       stop_det
);

  logic scl_rise;
  logic scl_fall;
  logic start_s;
  logic stop_s;
  logic sda_s;

  i2c_target_bus_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .scl_i       (scl),
    .sda_i       (sda_in),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_s),
    .stop_det_o  (stop_s),
    .sda_s_o     (sda_s)
  );

  state_e     state_q;
  logic [2:0] bitcnt_q;
  logic [7:0] sr_q;
  logic [7:0] sr_d;
  logic [7:0] tx_q;
  logic       sda_oe_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       rx_first_q;
  logic       first_q;
  logic       tx_req_q;
  logic       latch_q;
  logic       busy_q;
  logic       stop_q;
  logic       rw_q;
  // ACK slot: 0 = waiting to drive, 1 = driving
  logic       phase_q;

  assign sr_d = {sr_q[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      sr_q       <= '0;
      tx_q       <= '0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      first_q    <= 1'b0;
      tx_req_q   <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      stop_q     <= 1'b0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      stop_q     <= 1'b0;
      // tx_data is sampled one cycle after the tx_req strobe
      latch_q    <= tx_req_q;
      if (latch_q) tx_q <= tx_data;

      if (start_s) begin
        state_q  <= ST_ADDR;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
        phase_q  <= 1'b0;
      end else if (stop_s) begin
        state_q  <= ST_IDLE;
        busy_q   <= 1'b0;
        stop_q   <= 1'b1;
        sda_oe_q <= 1'b0;
        phase_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            sda_oe_q <= 1'b0;
          end
          ST_ADDR: begin
            if (scl_rise) begin
              sr_q     <= sr_d;
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == BIT_LAST) begin
                if (sr_d[7:1] == ADDR) begin
                  state_q <= ST_ADDR_ACK;
                  busy_q  <= 1'b1;
                  rw_q    <= sr_d[0];
                  first_q <= 1'b1;
                  phase_q <= 1'b0;
                  if (sr_d[0] == I2C_RW_READ)
                    tx_req_q <= 1'b1;
                end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_oe_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                phase_q  <= 1'b0;
                if (rw_q == I2C_RW_READ) begin
                  // MSB goes out now; bitcnt counts bits driven
                  sda_oe_q <= ~tx_q[7];
                  tx_q     <= {tx_q[6:0], 1'b0};
                  bitcnt_q <= 3'd1;
                  state_q  <= ST_RD;
                end else begin
                  sda_oe_q <= 1'b0;
                  bitcnt_q <= '0;
                  state_q  <= ST_WR;
                end
              end
            end
          end
          ST_WR: begin
            if (scl_rise) begin
              sr_q     <= sr_d;
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == BIT_LAST) begin
                rx_data_q  <= sr_d;
                rx_valid_q <= 1'b1;
                rx_first_q <= first_q;
                first_q    <= 1'b0;
                phase_q    <= 1'b0;
                state_q    <= ST_WR_ACK;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              if (!phase_q) begin
                sda_oe_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                phase_q  <= 1'b0;
                bitcnt_q <= '0;
                state_q  <= ST_WR;
              end
            end
          end
          ST_RD: begin
            if (scl_fall) begin
              // bitcnt wraps to 0 once all 8 bits are out
              if (bitcnt_q == 3'd0) begin
                sda_oe_q <= 1'b0;
                phase_q  <= 1'b0;
                state_q  <= ST_RD_ACK;
              end else begin
                sda_oe_q <= ~tx_q[7];
                tx_q     <= {tx_q[6:0], 1'b0};
                bitcnt_q <= bitcnt_q + 3'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise && !phase_q) begin
              if (!sda_s) begin
                tx_req_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
                state_q  <= ST_IDLE;
              end
            end else if (scl_fall && phase_q) begin
              sda_oe_q <= ~tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
              bitcnt_q <= 3'd1;
              phase_q  <= 1'b0;
              state_q  <= ST_RD;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_first = rx_first_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign stop_det = stop_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: BFM master at SCL = clk/16, wired-AND SDA,
// scoreboard queues for written bytes and served read bytes.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       tx_req;
  logic [7:0] tx_data = 8'h00;
  logic       busy;
  logic       stop_det;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int n_txreq   = 0;
  int n_stop    = 0;
  int n_sda_low = 0;
  int n_busy    = 0;

  logic [8:0] rx_exp[$];
  logic [8:0] rx_got[$];
  logic [7:0] tx_src[$];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target dut (
    .clk      (clk),
    .reset    (rst),
    .scl      (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_first (rx_first),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .busy     (busy),
    .stop_det (stop_det)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish, passed=%0d total=%0d",
             pass_cnt, check_cnt);
    $fatal(1);
  end

  // monitor: collects DUT output events, answers tx_req
  always @(negedge clk) begin
    if (rx_valid) rx_got.push_back({rx_first, rx_data});
    if (tx_req) begin
      n_txreq++;
      tx_data = (tx_src.size() > 0) ? tx_src.pop_front() : 8'hFF;
    end
    if (stop_det) n_stop++;
    if (sda_oe) n_sda_low++;
    if (busy) n_busy++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b0; wait_clk(8);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    sda_m = 1'b1; wait_clk(8);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(4);
    scl_m = 1'b1; wait_clk(4);
    b = sda_bus;  wait_clk(4);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(4);
    check_cnt++;
    if ({sda_oe, rx_valid, rx_first, tx_req, busy, stop_det} !== 6'b0)
      $display("FAIL reset_ctl: got %b want 000000",
               {sda_oe, rx_valid, rx_first, tx_req, busy, stop_det});
    else pass_cnt++;
    check_cnt++;
    if (rx_data !== 8'h00)
      $display("FAIL reset_rx_data: got %h want 00", rx_data);
    else pass_cnt++;
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_write_multi();
    logic ack;
    logic [7:0] d[3];
    int s0;
    logic [8:0] e, g;
    d[0] = 8'hAB; d[1] = 8'hCD; d[2] = 8'hEF;
    s0 = n_stop;
    bus_start();
    write_byte(8'hB0, ack);
    check_cnt++;
    if (ack !== 1'b0) $display("FAIL wr_addr_ack: got %b want 0", ack);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      rx_exp.push_back({(i == 0), d[i]});
      write_byte(d[i], ack);
      check_cnt++;
      if (ack !== 1'b0)
        $display("FAIL wr_data_ack%0d: got %b want 0", i, ack);
      else pass_cnt++;
    end
    bus_stop();
    wait_clk(6);
    check_cnt++;
    if (rx_got.size() !== rx_exp.size())
      $display("FAIL wr_rx_count: got %0d want %0d",
               rx_got.size(), rx_exp.size());
    else pass_cnt++;
    while (rx_exp.size() > 0 && rx_got.size() > 0) begin
      e = rx_exp.pop_front();
      g = rx_got.pop_front();
      check_cnt++;
      if (g !== e) $display("FAIL wr_rx: got %h want %h", g, e);
      else pass_cnt++;
    end
    rx_exp.delete(); rx_got.delete();
    check_cnt++;
    if (n_stop - s0 !== 1)
      $display("FAIL wr_stop_det: got %0d want 1", n_stop - s0);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL wr_busy_end: got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_wrong_addr();
    logic ack0, ack1;
    n_sda_low = 0;
    n_busy    = 0;
    bus_start();
    write_byte(8'h42, ack0);
    write_byte(8'h55, ack1);
    bus_stop();
    wait_clk(6);
    check_cnt++;
    if ({ack0, ack1} !== 2'b11)
      $display("FAIL na_ack: got %b want 11", {ack0, ack1});
    else pass_cnt++;
    check_cnt++;
    if (n_sda_low !== 0)
      $display("FAIL na_sda_low: got %0d want 0", n_sda_low);
    else pass_cnt++;
    check_cnt++;
    if (n_busy !== 0) $display("FAIL na_busy: got %0d want 0", n_busy);
    else pass_cnt++;
    check_cnt++;
    if (rx_got.size() !== 0)
      $display("FAIL na_rx_count: got %0d want 0", rx_got.size());
    else pass_cnt++;
    rx_got.delete();
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] v0, v1;
    int t0;
    t0 = n_txreq;
    tx_src.push_back(8'h3C);
    tx_src.push_back(8'hA5);
    bus_start();
    write_byte(8'hB1, ack);
    check_cnt++;
    if (ack !== 1'b0) $display("FAIL rd_addr_ack: got %b want 0", ack);
    else pass_cnt++;
    read_byte(1'b0, v0);
    read_byte(1'b1, v1);
    check_cnt++;
    if (v0 !== 8'h3C) $display("FAIL rd_byte0: got %h want 3c", v0);
    else pass_cnt++;
    check_cnt++;
    if (v1 !== 8'hA5) $display("FAIL rd_byte1: got %h want a5", v1);
    else pass_cnt++;
    check_cnt++;
    if ({sda_oe, busy} !== 2'b00)
      $display("FAIL rd_release: got oe/busy %b want 00", {sda_oe, busy});
    else pass_cnt++;
    bus_stop();
    wait_clk(6);
    check_cnt++;
    if (n_txreq - t0 !== 2)
      $display("FAIL rd_tx_req: got %0d want 2", n_txreq - t0);
    else pass_cnt++;
  endtask

  task automatic test_repeated_start();
    logic ack0, ack1, ack2;
    logic [7:0] v;
    logic [8:0] e, g;
    int s0;
    tx_src.push_back(8'h99);
    rx_exp.push_back({1'b1, 8'h10});
    bus_start();
    write_byte(8'hB0, ack0);
    write_byte(8'h10, ack1);
    s0 = n_stop;
    bus_start();
    write_byte(8'hB1, ack2);
    read_byte(1'b1, v);
    check_cnt++;
    if (n_stop !== s0)
      $display("FAIL rs_no_stop: got %0d want %0d", n_stop, s0);
    else pass_cnt++;
    bus_stop();
    wait_clk(6);
    check_cnt++;
    if ({ack0, ack1, ack2} !== 3'b000)
      $display("FAIL rs_acks: got %b want 000", {ack0, ack1, ack2});
    else pass_cnt++;
    check_cnt++;
    if (v !== 8'h99) $display("FAIL rs_read: got %h want 99", v);
    else pass_cnt++;
    check_cnt++;
    if (rx_got.size() !== rx_exp.size())
      $display("FAIL rs_rx_count: got %0d want %0d",
               rx_got.size(), rx_exp.size());
    else pass_cnt++;
    while (rx_exp.size() > 0 && rx_got.size() > 0) begin
      e = rx_exp.pop_front();
      g = rx_got.pop_front();
      check_cnt++;
      if (g !== e) $display("FAIL rs_rx: got %h want %h", g, e);
      else pass_cnt++;
    end
    rx_exp.delete(); rx_got.delete();
  endtask

  task automatic test_stop_mid();
    logic ack;
    logic [8:0] e, g;
    bus_start();
    write_byte(8'hB0, ack);
    write_bit(1'b1); write_bit(1'b0);
    write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    wait_clk(6);
    check_cnt++;
    if (rx_got.size() !== 0)
      $display("FAIL sm_partial_rx: got %0d want 0", rx_got.size());
    else pass_cnt++;
    check_cnt++;
    if ({busy, sda_oe} !== 2'b00)
      $display("FAIL sm_idle: got busy/oe %b want 00", {busy, sda_oe});
    else pass_cnt++;
    rx_got.delete();
    rx_exp.push_back({1'b1, 8'h77});
    bus_start();
    write_byte(8'hB0, ack);
    write_byte(8'h77, ack);
    bus_stop();
    wait_clk(6);
    check_cnt++;
    if (rx_got.size() !== rx_exp.size())
      $display("FAIL sm_rx_count: got %0d want %0d",
               rx_got.size(), rx_exp.size());
    else pass_cnt++;
    while (rx_exp.size() > 0 && rx_got.size() > 0) begin
      e = rx_exp.pop_front();
      g = rx_got.pop_front();
      check_cnt++;
      if (g !== e) $display("FAIL sm_rx: got %h want %h", g, e);
      else pass_cnt++;
    end
    rx_exp.delete(); rx_got.delete();
  endtask

  task automatic test_reset_ack();
    logic ack;
    logic [7:0] a;
    logic [8:0] e, g;
    int t;
    a = 8'hB0;
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(a[i]);
    t = 0;
    while (sda_oe !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check_cnt++;
    if (sda_oe !== 1'b1)
      $display("FAIL ra_ack_slot: got %b want 1 (timeout)", sda_oe);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_cnt++;
    if (sda_oe !== 1'b0) $display("FAIL ra_release: got %b want 0", sda_oe);
    else pass_cnt++;
    check_cnt++;
    if ({rx_data, rx_valid, rx_first, tx_req, busy, stop_det} !== 13'b0)
      $display("FAIL ra_outputs: got %h want 0000",
               {rx_data, rx_valid, rx_first, tx_req, busy, stop_det});
    else pass_cnt++;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    bus_stop();
    rx_got.delete();
    rx_exp.push_back({1'b1, 8'h5A});
    bus_start();
    write_byte(8'hB0, ack);
    write_byte(8'h5A, ack);
    bus_stop();
    wait_clk(6);
    check_cnt++;
    if (rx_got.size() !== rx_exp.size())
      $display("FAIL ra_rx_count: got %0d want %0d",
               rx_got.size(), rx_exp.size());
    else pass_cnt++;
    while (rx_exp.size() > 0 && rx_got.size() > 0) begin
      e = rx_exp.pop_front();
      g = rx_got.pop_front();
      check_cnt++;
      if (g !== e) $display("FAIL ra_rx: got %h want %h", g, e);
      else pass_cnt++;
    end
    rx_exp.delete(); rx_got.delete();
  endtask

  initial begin
    test_reset();
    test_write_multi();
    test_wrong_addr();
    test_read();
    test_repeated_start();
    test_stop_mid();
    test_reset_ack();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
